idx_mask_builder: RTL and testbench



---
 rtl/idx_mask_builder.sv | 235 +++++++++++++++++++++++
 tb/tb_idx_mask_builder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/idx_mask_builder.sv
// ---------------------------------------------------------------------------
// idx_mask_builder
//
// Decodes a stream of bit indices and OR-accumulates them into a WIDTH-bit
// mask. The beat flagged last completes the mask, which is then offered
// downstream through a valid/ready handshake together with its popcount and
// a sticky "some index was out of range" flag.
//
// Index orientation (FLIP) matches the leading-zero counter: FLIP=0 means
// index k sets bit k, FLIP=1 means index k sets bit WIDTH-1-k.
//
// Optional build macro: COMMON_CELLS_IDX_MASK_SKID_EN
//   undefined : one output register; idx_ready_o=0 while a mask is pending.
//   defined   : accumulation continues while a mask is pending; a second
//               completed mask is parked until the output drains, and is
//               loaded in the handshake cycle (no bubble).
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous abort of accumulation and any pending output
//   idx_valid_i   index beat valid
//   idx_ready_o   index beat accepted when idx_valid_i && idx_ready_o
//   idx_i         bit index (IDX_W bits)
//   idx_last_i    final beat of the current mask
//   mask_valid_o  completed mask valid
//   mask_ready_i  downstream accepts mask
//   mask_o        completed mask (WIDTH bits)
//   count_o       popcount of mask_o (CNT_W bits)
//   oor_o         one or more beats of this mask had idx_i >= WIDTH
// ---------------------------------------------------------------------------
module idx_mask_builder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FLIP  = 0,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             idx_valid_i,
    output logic             idx_ready_o,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             idx_last_i,
    output logic             mask_valid_o,
    input  logic             mask_ready_i,
    output logic [WIDTH-1:0] mask_o,
    output logic [CNT_W-1:0] count_o,
    output logic             oor_o
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic               oor_acc_reg, oor_acc_next;
    logic [WIDTH-1:0]   mask_reg, mask_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               oor_reg, oor_next;

`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
    logic               park_valid_reg, park_valid_next;
    logic [WIDTH-1:0]   park_mask_reg, park_mask_next;
    logic [CNT_W-1:0]   park_count_reg, park_count_next;
    logic               park_oor_reg, park_oor_next;
`endif

    logic [WIDTH-1:0]   dec;
    logic [IDX_W:0]     idx_ext;
    logic               oor_beat;
    logic               accept;
    logic               complete;
    logic [WIDTH-1:0]   comp_mask;
    logic [CNT_W-1:0]   comp_cnt;
    logic               comp_oor;

    // One-hot decode. An out-of-range index matches no position, so it
    // contributes no bit; it only raises the sticky flag.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            localparam int unsigned POS = (FLIP != 0) ? (WIDTH - 1 - gi) : gi;
            assign dec[gi] = (idx_i == IDX_W'(POS));
        end
    endgenerate

    // One extra bit so WIDTH itself is representable in the comparison.
    assign idx_ext  = {1'b0, idx_i};
    assign oor_beat = (idx_ext >= (IDX_W + 1)'(WIDTH));

`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
    // Only a parked mask can stall the index stream.
    assign idx_ready_o = !park_valid_reg;
`else
    assign idx_ready_o = (state_reg == ACCUM);
`endif

    // A beat arriving together with clear_i is dropped even if handshaken.
    assign accept    = idx_valid_i && idx_ready_o && !clear_i;
    assign complete  = accept && idx_last_i;
    assign comp_mask = acc_reg | dec;
    assign comp_oor  = oor_acc_reg | oor_beat;

    always_comb begin
        comp_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            comp_cnt = comp_cnt + CNT_W'(comp_mask[i]);
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        oor_acc_next = oor_acc_reg;
        mask_next    = mask_reg;
        count_next   = count_reg;
        oor_next     = oor_reg;
`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
        park_valid_next = park_valid_reg;
        park_mask_next  = park_mask_reg;
        park_count_next = park_count_reg;
        park_oor_next   = park_oor_reg;

        // Accumulator runs independently of the output register.
        if (complete) begin
            acc_next     = '0;
            oor_acc_next = 1'b0;
        end else if (accept) begin
            acc_next     = comp_mask;
            oor_acc_next = comp_oor;
        end

        case (state_reg)
            ACCUM: begin
                if (complete) begin
                    mask_next  = comp_mask;
                    count_next = comp_cnt;
                    oor_next   = comp_oor;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (mask_ready_i) begin
                    // Handshake cycle: refill straight away if anything waits.
                    if (park_valid_reg) begin
                        mask_next       = park_mask_reg;
                        count_next      = park_count_reg;
                        oor_next        = park_oor_reg;
                        park_valid_next = 1'b0;
                    end else if (complete) begin
                        mask_next  = comp_mask;
                        count_next = comp_cnt;
                        oor_next   = comp_oor;
                    end else begin
                        state_next = ACCUM;
                    end
                end else if (complete) begin
                    park_mask_next  = comp_mask;
                    park_count_next = comp_cnt;
                    park_oor_next   = comp_oor;
                    park_valid_next = 1'b1;
                end
            end
            default: state_next = ACCUM;
        endcase
`else
        case (state_reg)
            ACCUM: begin
                if (complete) begin
                    mask_next    = comp_mask;
                    count_next   = comp_cnt;
                    oor_next     = comp_oor;
                    acc_next     = '0;
                    oor_acc_next = 1'b0;
                    state_next   = HOLD;
                end else if (accept) begin
                    acc_next     = comp_mask;
                    oor_acc_next = comp_oor;
                end
            end
            HOLD: begin
                if (mask_ready_i) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
`endif

        // Abort wins over everything, including a pending output.
        if (clear_i) begin
            acc_next     = '0;
            oor_acc_next = 1'b0;
            state_next   = ACCUM;
`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
            park_valid_next = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ACCUM;
            acc_reg     <= '0;
            oor_acc_reg <= 1'b0;
            mask_reg    <= '0;
            count_reg   <= '0;
            oor_reg     <= 1'b0;
`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
            park_valid_reg <= 1'b0;
            park_mask_reg  <= '0;
            park_count_reg <= '0;
            park_oor_reg   <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            oor_acc_reg <= oor_acc_next;
            mask_reg    <= mask_next;
            count_reg   <= count_next;
            oor_reg     <= oor_next;
`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
            park_valid_reg <= park_valid_next;
            park_mask_reg  <= park_mask_next;
            park_count_reg <= park_count_next;
            park_oor_reg   <= park_oor_next;
`endif
        end
    end

    assign mask_valid_o = (state_reg == HOLD);
    assign mask_o       = mask_reg;
    assign count_o      = count_reg;
    assign oor_o        = oor_reg;

endmodule

// File: tb/tb_idx_mask_builder.sv
// ---------------------------------------------------------------------------
// tb_idx_mask_builder
//
// Four instances share one index stream: WIDTH=8/FLIP=0, WIDTH=8/FLIP=1,
// WIDTH=6 (non power of two, out-of-range indices 6 and 7) and WIDTH=1
// (driven from idx[0]). Each scenario task checks its own expected values.
// ---------------------------------------------------------------------------
module tb_idx_mask_builder;

`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
    localparam logic HOLD_READY = 1'b1;
`else
    localparam logic HOLD_READY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       idx_valid;
    logic [2:0] idx;
    logic       idx_last;
    logic       mask_ready;

    logic       r8, v8, o8;
    logic [7:0] m8;
    logic [3:0] c8;
    logic       rf, vf, of;
    logic [7:0] mf;
    logic [3:0] cf;
    logic       r6, v6, o6;
    logic [5:0] m6;
    logic [2:0] c6;
    logic       r1, v1, o1;
    logic [0:0] m1;
    logic [0:0] c1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    idx_mask_builder #(.WIDTH(8), .FLIP(0)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .idx_valid_i(idx_valid), .idx_ready_o(r8), .idx_i(idx), .idx_last_i(idx_last),
        .mask_valid_o(v8), .mask_ready_i(mask_ready), .mask_o(m8), .count_o(c8), .oor_o(o8)
    );

    idx_mask_builder #(.WIDTH(8), .FLIP(1)) dutf (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .idx_valid_i(idx_valid), .idx_ready_o(rf), .idx_i(idx), .idx_last_i(idx_last),
        .mask_valid_o(vf), .mask_ready_i(mask_ready), .mask_o(mf), .count_o(cf), .oor_o(of)
    );

    idx_mask_builder #(.WIDTH(6), .FLIP(0)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .idx_valid_i(idx_valid), .idx_ready_o(r6), .idx_i(idx), .idx_last_i(idx_last),
        .mask_valid_o(v6), .mask_ready_i(mask_ready), .mask_o(m6), .count_o(c6), .oor_o(o6)
    );

    idx_mask_builder #(.WIDTH(1), .FLIP(0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .idx_valid_i(idx_valid), .idx_ready_o(r1), .idx_i(idx[0:0]), .idx_last_i(idx_last),
        .mask_valid_o(v1), .mask_ready_i(mask_ready), .mask_o(m1), .count_o(c1), .oor_o(o1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] i, input logic l);
        idx_valid = 1'b1;
        idx       = i;
        idx_last  = l;
        step();
        idx_valid = 1'b0;
        idx_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; idx_valid = 1'b0; idx = '0; idx_last = 1'b0; mask_ready = 1'b1;
        repeat (2) step();
        checks++; if (v8 !== 1'b0) begin $display("FAIL reset_valid8 got %b exp 0", v8); fails++; end
        checks++; if (m8 !== 8'h00) begin $display("FAIL reset_mask8 got %h exp 00", m8); fails++; end
        checks++; if (c8 !== 4'd0) begin $display("FAIL reset_count8 got %0d exp 0", c8); fails++; end
        checks++; if (o8 !== 1'b0) begin $display("FAIL reset_oor8 got %b exp 0", o8); fails++; end
        checks++; if ({vf, v6, v1} !== 3'b000) begin $display("FAIL reset_valid_all got %b exp 000", {vf, v6, v1}); fails++; end
        checks++; if ({of, o6, o1, cf, c6, c1} !== '0) begin $display("FAIL reset_misc got %b exp 0", {of, o6, o1, cf, c6, c1}); fails++; end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if ({r8, rf, r6, r1} !== 4'b1111) begin $display("FAIL reset_ready got %b exp 1111", {r8, rf, r6, r1}); fails++; end
        $display("reset done: ready=%b", {r8, rf, r6, r1});
    endtask

    task automatic test_basic();
        mask_ready = 1'b1;
        send(3'd0, 1'b0);
        send(3'd3, 1'b0);
        send(3'd7, 1'b1);
        $display("basic: m8=%h c8=%0d o8=%b mf=%h m6=%h o6=%b", m8, c8, o8, mf, m6, o6);
        checks++; if (v8 !== 1'b1) begin $display("FAIL basic_valid8 got %b exp 1", v8); fails++; end
        checks++; if (m8 !== 8'h89) begin $display("FAIL basic_mask8 got %h exp 89", m8); fails++; end
        checks++; if (c8 !== 4'd3) begin $display("FAIL basic_count8 got %0d exp 3", c8); fails++; end
        checks++; if (o8 !== 1'b0) begin $display("FAIL basic_oor8 got %b exp 0", o8); fails++; end
        checks++; if ({mf, cf} !== {8'h91, 4'd3}) begin $display("FAIL basic_flip got %h/%0d exp 91/3", mf, cf); fails++; end
        checks++; if ({m6, c6, o6} !== {6'h09, 3'd2, 1'b1}) begin $display("FAIL basic_w6 got %h/%0d/%b exp 09/2/1", m6, c6, o6); fails++; end
        checks++; if ({v1, m1, c1, o1} !== 4'b1111) begin $display("FAIL basic_w1 got %b exp 1111", {v1, m1, c1, o1}); fails++; end
        step();
        checks++; if (v8 !== 1'b0) begin $display("FAIL basic_one_cycle got %b exp 0", v8); fails++; end
        checks++; if (r8 !== 1'b1) begin $display("FAIL basic_ready_after got %b exp 1", r8); fails++; end
    endtask

    task automatic test_flip();
        send(3'd0, 1'b0);
        send(3'd1, 1'b1);
        $display("flip: mf=%h cf=%0d m8=%h", mf, cf, m8);
        checks++; if ({vf, mf} !== {1'b1, 8'hC0}) begin $display("FAIL flip_mask got %b/%h exp 1/c0", vf, mf); fails++; end
        checks++; if (cf !== 4'd2) begin $display("FAIL flip_count got %0d exp 2", cf); fails++; end
        checks++; if (m8 !== 8'h03) begin $display("FAIL flip_ref_mask8 got %h exp 03", m8); fails++; end
        checks++; if (of !== 1'b0) begin $display("FAIL flip_oor got %b exp 0", of); fails++; end
        step();
        checks++; if (vf !== 1'b0) begin $display("FAIL flip_drain got %b exp 0", vf); fails++; end
    endtask

    task automatic test_oor();
        send(3'd2, 1'b0);
        send(3'd6, 1'b1);
        $display("oor: m6=%h c6=%0d o6=%b m8=%h", m6, c6, o6, m8);
        checks++; if ({v6, m6} !== {1'b1, 6'h04}) begin $display("FAIL oor_mask6 got %b/%h exp 1/04", v6, m6); fails++; end
        checks++; if (c6 !== 3'd1) begin $display("FAIL oor_count6 got %0d exp 1", c6); fails++; end
        checks++; if (o6 !== 1'b1) begin $display("FAIL oor_flag6 got %b exp 1", o6); fails++; end
        checks++; if ({m8, c8, o8} !== {8'h44, 4'd2, 1'b0}) begin $display("FAIL oor_ref8 got %h/%0d/%b exp 44/2/0", m8, c8, o8); fails++; end
        step();
        send(3'd1, 1'b1);
        $display("oor next: m6=%h o6=%b", m6, o6);
        checks++; if ({m6, c6} !== {6'h02, 3'd1}) begin $display("FAIL oor_next_mask6 got %h/%0d exp 02/1", m6, c6); fails++; end
        checks++; if (o6 !== 1'b0) begin $display("FAIL oor_flag_cleared got %b exp 0", o6); fails++; end
        checks++; if (o1 !== 1'b1) begin $display("FAIL oor_w1 got %b exp 1", o1); fails++; end
        step();
    endtask

    task automatic test_backpressure();
        mask_ready = 1'b0;
        send(3'd2, 1'b0);
        send(3'd2, 1'b0);
        send(3'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            $display("hold cycle %0d: v8=%b m8=%h c8=%0d r8=%b", i, v8, m8, c8, r8);
            checks++; if ({v8, m8, c8} !== {1'b1, 8'h04, 4'd1}) begin $display("FAIL hold_stable cyc%0d got %b/%h/%0d exp 1/04/1", i, v8, m8, c8); fails++; end
            checks++; if (r8 !== HOLD_READY) begin $display("FAIL hold_ready cyc%0d got %b exp %b", i, r8, HOLD_READY); fails++; end
            step();
        end
        mask_ready = 1'b1;
        step();
        checks++; if ({v8, r8} !== 2'b01) begin $display("FAIL hold_release got %b exp 01", {v8, r8}); fails++; end
    endtask

    task automatic test_clear();
        mask_ready = 1'b1;
        send(3'd1, 1'b0);
        send(3'd4, 1'b0);
        clear = 1'b1; idx_valid = 1'b1; idx = 3'd6; idx_last = 1'b1;
        step();
        clear = 1'b0; idx_valid = 1'b0; idx_last = 1'b0;
        checks++; if (v8 !== 1'b0) begin $display("FAIL clear_drop_beat got %b exp 0", v8); fails++; end
        send(3'd5, 1'b1);
        $display("clear: m8=%h mf=%h m6=%h o6=%b", m8, mf, m6, o6);
        checks++; if ({v8, m8, c8} !== {1'b1, 8'h20, 4'd1}) begin $display("FAIL clear_mask8 got %b/%h/%0d exp 1/20/1", v8, m8, c8); fails++; end
        checks++; if (mf !== 8'h04) begin $display("FAIL clear_maskf got %h exp 04", mf); fails++; end
        checks++; if ({m6, o6} !== {6'h20, 1'b0}) begin $display("FAIL clear_w6 got %h/%b exp 20/0", m6, o6); fails++; end
        step();
        mask_ready = 1'b0;
        send(3'd3, 1'b1);
        checks++; if (v8 !== 1'b1) begin $display("FAIL clear_pending got %b exp 1", v8); fails++; end
        clear = 1'b1;
        step();
        clear = 1'b0;
        $display("clear withdraw: v8=%b r8=%b", v8, r8);
        checks++; if ({v8, r8} !== 2'b01) begin $display("FAIL clear_withdraw got %b exp 01", {v8, r8}); fails++; end
    endtask

    task automatic test_async_reset();
        mask_ready = 1'b0;
        send(3'd7, 1'b1);
        checks++; if ({v8, m8} !== {1'b1, 8'h80}) begin $display("FAIL areset_pre got %b/%h exp 1/80", v8, m8); fails++; end
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: v8=%b m8=%h", v8, m8);
        checks++; if ({v8, m8, c8} !== {1'b0, 8'h00, 4'd0}) begin $display("FAIL areset_clear got %b/%h/%0d exp 0/00/0", v8, m8, c8); fails++; end
        @(negedge clk);
        rst_n = 1'b1;
        mask_ready = 1'b1;
        #1;
        checks++; if (r8 !== 1'b1) begin $display("FAIL areset_ready got %b exp 1", r8); fails++; end
    endtask

`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
    task automatic test_back_to_back();
        mask_ready = 1'b0;
        send(3'd0, 1'b1);
        checks++; if ({v8, m8, r8} !== {1'b1, 8'h01, 1'b1}) begin $display("FAIL skid_a got %b/%h/%b exp 1/01/1", v8, m8, r8); fails++; end
        send(3'd7, 1'b1);
        checks++; if ({v8, m8, r8} !== {1'b1, 8'h01, 1'b0}) begin $display("FAIL skid_park got %b/%h/%b exp 1/01/0", v8, m8, r8); fails++; end
        mask_ready = 1'b1;
        step();
        $display("skid: v8=%b m8=%h c8=%0d", v8, m8, c8);
        checks++; if ({v8, m8, c8} !== {1'b1, 8'h80, 4'd1}) begin $display("FAIL skid_b got %b/%h/%0d exp 1/80/1", v8, m8, c8); fails++; end
        step();
        checks++; if ({v8, r8} !== 2'b01) begin $display("FAIL skid_drain got %b exp 01", {v8, r8}); fails++; end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_oor();
        test_backpressure();
        test_clear();
        test_async_reset();
`ifdef COMMON_CELLS_IDX_MASK_SKID_EN
        test_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
